f_wb_scheduler: RTL and testbench
=================================

F_WB_SCHEDULER -- requirements
Module: f_wb_scheduler

Interface
REQ-001 The block SHALL have parameter NUM_REGS, default 32, giving the FP register count; the rd/rs width SHALL be $clog2(NUM_REGS).
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have these issue ports:
- issue_valid, input, 1: FPU op issue request.
- issue_rd, input, 5: destination of the issued op.
- issue_ready, output, 1: issue accepted this cycle.
REQ-005 The block SHALL have these FPU result ports:
- fpu_done, input, 1: FPU result valid.
- fpu_rd, input, 5: result destination.
- fpu_data, input, 32: result value.
- fpu_flags, input, 5: NV/DZ/OF/UF/NX flags.
- fpu_ready, output, 1: result can be accepted.
REQ-006 The block SHALL have these load ports:
- load_valid, input, 1: FLW data valid.
- load_rd, input, 5: load destination.
- load_data, input, 32: load value.
REQ-007 The block SHALL have these register-file write port outputs:
- rf_wen, output, 1: write enable.
- rf_rd, output, 5: write destination.
- rf_wdata, output, 32: write data.
REQ-008 The block SHALL have these hazard and CSR ports:
- rs1, rs2, inputs, 5 each: read addresses.
- rs1_busy, rs2_busy, outputs, 1 each: the addressed register has a pending FPU write.
- busy, output, NUM_REGS: the scoreboard.
- fflags_clr, input, 1: CSR clear of the sticky flags.
- fflags, output, 5: sticky accrued flags.

Function
REQ-009 Loads SHALL have absolute priority on the write port and SHALL never be stalled.
REQ-010 Write-port outputs SHALL be registered, with 1-cycle latency from the accepted source to rf_wen.
REQ-011 A 1-entry FPU result buffer SHALL implement the states EMPTY and HELD.
REQ-012 EMPTY, fpu_done and !load_valid: the FPU result SHALL be written next cycle and the state SHALL stay EMPTY.
REQ-013 EMPTY, fpu_done and load_valid: the load SHALL be written, the FPU result SHALL be captured, and the state SHALL go to HELD.
REQ-014 HELD, !load_valid: the buffered result SHALL be written and the state SHALL go to EMPTY; HELD, load_valid: the load SHALL be written and the state SHALL stay HELD.
REQ-015 fpu_ready SHALL be the expression (state==EMPTY).
REQ-016 fpu_done while fpu_ready=0 SHALL be ignored, and an assertion SHALL fire.
REQ-017 issue_ready SHALL be issue_valid && !busy[issue_rd], which blocks WAW to a pending register.
REQ-018 An accepted issue SHALL set busy[issue_rd] on the next edge.
REQ-019 An FPU write on the write port SHALL clear busy[rf_rd] in the cycle rf_wen is asserted.
REQ-020 When a set and a clear target the same index in the same cycle, the set SHALL win.
REQ-021 A load to a busy register SHALL write the data and SHALL leave busy unchanged.
REQ-022 rs1_busy and rs2_busy SHALL be combinational lookups of busy.
REQ-023 fflags SHALL OR in fpu_flags on each FPU-sourced write.
REQ-024 fflags_clr SHALL zero fflags; when fflags_clr coincides with a flag update, the new flags SHALL be kept (clear then OR).
REQ-025 Writes to register 0 SHALL be legal; the FP register file has no hardwired zero.

Reset
REQ-026 On rst the block SHALL set state=EMPTY, busy=0, fflags=0, rf_wen=0, rf_rd=0, and rf_wdata=0.
REQ-027 A reset mid-HELD SHALL discard the buffered result.
REQ-028 After reset deasserts, fpu_ready SHALL be 1 in the first cycle.

Configuration
REQ-029 With FP_WB_FWD_EN defined, the block SHALL add outputs rs1_fwd and rs2_fwd (1 bit) and fwd_data (32 bit).
REQ-030 With FP_WB_FWD_EN defined, rsN_fwd SHALL be 1 when rf_wen && rf_rd==rsN, and fwd_data SHALL equal rf_wdata.
REQ-031 With FP_WB_FWD_EN defined, rsN_busy SHALL be masked to 0 when rsN_fwd is 1.
REQ-032 Without FP_WB_FWD_EN, these ports SHALL be absent and rsN_busy SHALL remain unmasked.

Structure
REQ-033 Package f_wb_pkg SHALL hold the buffer state enum, the flag-vector typedef (5 bits), and the reg-index typedef.
REQ-034 Sub-module f_scoreboard SHALL own busy set/clear and the rs lookups; the top-level SHALL hold the arbitration, buffer, and flags.

Verification
REQ-035 A bench SHALL drive reset, then fpu_done rd=3 data=0x3F800000 flags=0x01; the next cycle SHALL show rf_wen=1, rf_rd=3, and fflags=0x01.
REQ-036 A bench SHALL drive load_valid rd=5 and fpu_done rd=7 in the same cycle; the bench SHALL see the load to 5 at t+1, the FPU write to 7 at t+2, and fpu_ready=0 at t+1.
REQ-037 A bench SHALL hold HELD for 3 cycles of back-to-back loads; the buffered result SHALL be written in the first load-free cycle, with no data lost.
REQ-038 A bench SHALL issue rd=9, then issue rd=9 again; the second issue SHALL see issue_ready=0 until the FPU write to 9, and rs1=9 SHALL show rs1_busy=1 meanwhile.
REQ-039 A bench SHALL assert rst while in HELD; state SHALL go to EMPTY, busy=0, and no write of the buffered value SHALL occur.
REQ-040 A bench SHALL drive fflags_clr together with an FPU write flags=0x04; fflags SHALL become 0x04.

Source files
------------

// File: rtl/f_wb_pkg.sv
// Shared types for the FP write-back scheduler: result-buffer state, flag vector
// and register index, plus the sticky-flag accrual helper.
package f_wb_pkg;

  localparam int FLAG_W    = 5;
  localparam int DATA_W    = 32;
  localparam int REG_IDX_W = 5;

  typedef enum logic {
    EMPTY = 1'b0,
    HELD  = 1'b1
  } buf_state_t;

  typedef logic [FLAG_W-1:0]    flags_t;
  typedef logic [REG_IDX_W-1:0] reg_idx_t;

  // Clear is applied before the OR so flags arriving with a clear survive.
  function automatic flags_t accrue_flags(input flags_t cur, input logic clr,
                                          input logic upd, input flags_t add);
    accrue_flags = (clr ? '0 : cur) | (upd ? add : '0);
  endfunction

endpackage

// File: rtl/f_scoreboard.sv
// Pending-write scoreboard for the FP register file: one busy bit per register,
// set on issue, cleared on FPU write-back, with combinational read-port lookups.
module f_scoreboard
  import f_wb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en,
  input  logic [RW-1:0]       set_idx,
  input  logic                clr_en,
  input  logic [RW-1:0]       clr_idx,
  input  logic [RW-1:0]       rs1,
  input  logic [RW-1:0]       rs2,
  output logic [NUM_REGS-1:0] busy,
  output logic                rs1_busy,
  output logic                rs2_busy
);

  logic [NUM_REGS-1:0] busy_n;

  // Set is applied after clear so a same-index collision leaves the bit set.
  always_comb begin
    busy_n = busy;
    if (clr_en) busy_n[clr_idx] = 1'b0;
    if (set_en) busy_n[set_idx] = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_n;
  end

  assign rs1_busy = busy[rs1];
  assign rs2_busy = busy[rs2];

endmodule

// File: rtl/f_wb_scheduler.sv
// FP register-file write-back scheduler: loads win the write port, FPU results
// wait in a 1-entry buffer. Optional operand forwarding under FP_WB_FWD_EN.
module f_wb_scheduler
  import f_wb_pkg::*;
#(
  parameter int NUM_REGS = 32,
  localparam int RW      = $clog2(NUM_REGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  input  logic [RW-1:0]       issue_rd,
  output logic                issue_ready,
  input  logic                fpu_done,
  input  logic [RW-1:0]       fpu_rd,
  input  logic [DATA_W-1:0]   fpu_data,
  input  flags_t              fpu_flags,
  output logic                fpu_ready,
  input  logic                load_valid,
  input  logic [RW-1:0]       load_rd,
  input  logic [DATA_W-1:0]   load_data,
  output logic                rf_wen,
  output logic [RW-1:0]       rf_rd,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic [RW-1:0]       rs1,
  input  logic [RW-1:0]       rs2,
  output logic                rs1_busy,
  output logic                rs2_busy,
`ifdef FP_WB_FWD_EN
  output logic                rs1_fwd,
  output logic                rs2_fwd,
  output logic [DATA_W-1:0]   fwd_data,
`endif
  output logic [NUM_REGS-1:0] busy,
  input  logic                fflags_clr,
  output flags_t              fflags
);

  buf_state_t        state, state_n;
  logic              accept_fpu;
  logic              capture;
  logic [RW-1:0]     buf_rd;
  logic [DATA_W-1:0] buf_data;
  flags_t            buf_flags;

  logic              wen_n;
  logic              wr_fpu_n;
  logic [RW-1:0]     rd_n;
  logic [DATA_W-1:0] data_n;
  flags_t            wflags_n;
  logic              rf_fpu;
  logic              rs1_busy_raw, rs2_busy_raw;

  assign fpu_ready   = (state == EMPTY);
  assign accept_fpu  = fpu_done && fpu_ready;
  assign issue_ready = issue_valid && !busy[issue_rd];

  // Next state and write-port selection: load > buffered result > direct FPU.
  always_comb begin
    state_n  = state;
    capture  = 1'b0;
    wen_n    = 1'b0;
    wr_fpu_n = 1'b0;
    rd_n     = load_rd;
    data_n   = load_data;
    wflags_n = '0;

    case (state)
      EMPTY: begin
        if (accept_fpu && load_valid) begin
          state_n = HELD;
          capture = 1'b1;
        end
      end
      HELD: begin
        if (!load_valid) state_n = EMPTY;
      end
      default: state_n = EMPTY;
    endcase

    if (load_valid) begin
      wen_n = 1'b1;
    end else if (state == HELD) begin
      wen_n    = 1'b1;
      wr_fpu_n = 1'b1;
      rd_n     = buf_rd;
      data_n   = buf_data;
      wflags_n = buf_flags;
    end else if (accept_fpu) begin
      wen_n    = 1'b1;
      wr_fpu_n = 1'b1;
      rd_n     = fpu_rd;
      data_n   = fpu_data;
      wflags_n = fpu_flags;
    end
  end

  // Registered write port, buffer state and sticky flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= EMPTY;
      rf_wen   <= 1'b0;
      rf_fpu   <= 1'b0;
      rf_rd    <= '0;
      rf_wdata <= '0;
      fflags   <= '0;
    end else begin
      state  <= state_n;
      rf_wen <= wen_n;
      rf_fpu <= wr_fpu_n;
      if (wen_n) begin
        rf_rd    <= rd_n;
        rf_wdata <= data_n;
      end
      fflags <= accrue_flags(fflags, fflags_clr, wr_fpu_n, wflags_n);
    end
  end

  // Buffer payload needs no reset: reset forces EMPTY, which discards it.
  always_ff @(posedge clk) begin
    if (capture) begin
      buf_rd    <= fpu_rd;
      buf_data  <= fpu_data;
      buf_flags <= fpu_flags;
    end
  end

  f_scoreboard #(
    .NUM_REGS (NUM_REGS)
  ) u_scoreboard (
    .clk      (clk),
    .rst      (rst),
    .set_en   (issue_ready),
    .set_idx  (issue_rd),
    .clr_en   (rf_wen && rf_fpu),
    .clr_idx  (rf_rd),
    .rs1      (rs1),
    .rs2      (rs2),
    .busy     (busy),
    .rs1_busy (rs1_busy_raw),
    .rs2_busy (rs2_busy_raw)
  );

`ifdef FP_WB_FWD_EN
  assign rs1_fwd  = rf_wen && (rf_rd == rs1);
  assign rs2_fwd  = rf_wen && (rf_rd == rs2);
  assign fwd_data = rf_wdata;
  assign rs1_busy = rs1_busy_raw && !rs1_fwd;
  assign rs2_busy = rs2_busy_raw && !rs2_fwd;
`else
  assign rs1_busy = rs1_busy_raw;
  assign rs2_busy = rs2_busy_raw;
`endif

  // The buffer cannot take a result while HELD; the FPU must honour fpu_ready.
  a_no_done_when_full: assert property (@(posedge clk) disable iff (rst)
    !(fpu_done && !fpu_ready));

endmodule

// File: tb/tb_f_wb_scheduler.sv
// Scoreboard bench for f_wb_scheduler: directed scenarios then random traffic,
// checked against a transaction-level model of write ordering and busy tracking.
module tb_f_wb_scheduler;
  import f_wb_pkg::*;

  localparam int NR = 32;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          issue_valid = 1'b0, issue_ready;
  logic [4:0]    issue_rd = '0;
  logic          fpu_done = 1'b0, fpu_ready;
  logic [4:0]    fpu_rd = '0;
  logic [31:0]   fpu_data = '0;
  flags_t        fpu_flags = '0;
  logic          load_valid = 1'b0;
  logic [4:0]    load_rd = '0;
  logic [31:0]   load_data = '0;
  logic          rf_wen;
  logic [4:0]    rf_rd;
  logic [31:0]   rf_wdata;
  logic [4:0]    rs1 = '0, rs2 = '0;
  logic          rs1_busy, rs2_busy;
  logic [NR-1:0] busy;
  logic          fflags_clr = 1'b0;
  flags_t        fflags;

  f_wb_scheduler #(.NUM_REGS(NR)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .issue_ready(issue_ready),
    .fpu_done(fpu_done), .fpu_rd(fpu_rd), .fpu_data(fpu_data),
    .fpu_flags(fpu_flags), .fpu_ready(fpu_ready),
    .load_valid(load_valid), .load_rd(load_rd), .load_data(load_data),
    .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_wdata(rf_wdata),
    .rs1(rs1), .rs2(rs2), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .busy(busy), .fflags_clr(fflags_clr), .fflags(fflags)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct packed {
    logic        lv;
    logic [4:0]  lrd;
    logic [31:0] ld;
    logic        fd;
    logic [4:0]  frd;
    logic [31:0] fdat;
    logic [4:0]  ffl;
    logic        iv;
    logic [4:0]  ird;
    logic        clr;
    logic [4:0]  r1;
    logic [4:0]  r2;
  } stim_t;

  typedef struct { int cyc; logic [4:0] rd; logic [31:0] data; } wr_t;
  typedef struct {
    int cyc; logic fr; logic ir; logic b1; logic b2;
    logic [4:0] ff; logic [31:0] busy; logic rst_chk;
  } st_t;
  typedef struct { logic [4:0] rd; logic [31:0] data; logic [4:0] fl; } res_t;

  wr_t  wq[$];
  st_t  sq[$];

  // Reference model: results waiting for the port, registers with pending
  // FPU writes, sticky flags, ops issued but not yet completed by the FPU.
  res_t        pend[$];
  logic [31:0] busy_m = '0;
  logic [4:0]  ff_m = '0;
  logic        vis_fpu = 1'b0;
  logic [4:0]  vis_rd = '0;
  logic [4:0]  inflight[$];

  int checks = 0, passes = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
  endtask

  task automatic step(input stim_t t);
    st_t  s;
    res_t w;
    logic wv, wf;
    @(posedge clk); #1;
    load_valid = t.lv;  load_rd = t.lrd;  load_data = t.ld;
    fpu_done = t.fd;    fpu_rd = t.frd;   fpu_data = t.fdat; fpu_flags = t.ffl;
    issue_valid = t.iv; issue_rd = t.ird; fflags_clr = t.clr;
    rs1 = t.r1;         rs2 = t.r2;

    s.cyc = cyc; s.fr = (pend.size() == 0); s.ir = t.iv && !busy_m[t.ird];
    s.b1 = busy_m[t.r1]; s.b2 = busy_m[t.r2]; s.ff = ff_m; s.busy = busy_m;
    s.rst_chk = 1'b0;
    sq.push_back(s);

    if (t.fd) pend.push_back('{t.frd, t.fdat, t.ffl});
    w = '{5'd0, 32'd0, 5'd0};
    wv = 1'b0; wf = 1'b0;
    if (t.lv) begin
      wv = 1'b1; w = '{t.lrd, t.ld, 5'd0};
    end else if (pend.size() > 0) begin
      wv = 1'b1; wf = 1'b1; w = pend.pop_front();
    end
    if (wv) wq.push_back('{cyc + 1, w.rd, w.data});
    ff_m = (t.clr ? 5'd0 : ff_m) | (wf ? w.fl : 5'd0);
    if (vis_fpu) busy_m[vis_rd] = 1'b0;
    if (s.ir) begin
      busy_m[t.ird] = 1'b1;
      inflight.push_back(t.ird);
    end
    vis_fpu = wf; vis_rd = w.rd;
  endtask

  task automatic do_reset();
    st_t s;
    @(posedge clk); #1;
    load_valid = 0; fpu_done = 0; issue_valid = 0; fflags_clr = 0;
    rst = 1'b1;
    wq.delete(); pend.delete(); inflight.delete();
    busy_m = '0; ff_m = '0; vis_fpu = 1'b0;
    s = '{cyc, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 32'd0, 1'b1};
    sq.push_back(s);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  // Monitor: compares per-cycle state and every write-port transaction.
  always @(negedge clk) begin
    st_t s;
    wr_t w;
    if (sq.size() > 0 && sq[0].cyc == cyc) begin
      s = sq.pop_front();
      chk("fpu_ready", {31'd0, fpu_ready}, {31'd0, s.fr});
      chk("issue_ready", {31'd0, issue_ready}, {31'd0, s.ir});
      chk("rs1_busy", {31'd0, rs1_busy}, {31'd0, s.b1});
      chk("rs2_busy", {31'd0, rs2_busy}, {31'd0, s.b2});
      chk("fflags", {27'd0, fflags}, {27'd0, s.ff});
      chk("busy", busy, s.busy);
      if (s.rst_chk) begin
        chk("rst_rf_wen", {31'd0, rf_wen}, 32'd0);
        chk("rst_rf_rd", {27'd0, rf_rd}, 32'd0);
        chk("rst_rf_wdata", rf_wdata, 32'd0);
      end
    end
    if (rf_wen === 1'b1) begin
      if (wq.size() > 0 && wq[0].cyc == cyc) begin
        w = wq.pop_front();
        chk("wr_rd", {27'd0, rf_rd}, {27'd0, w.rd});
        chk("wr_data", rf_wdata, w.data);
      end else begin
        checks++;
        $display("FAIL unexpected_write cyc=%0d actual rd=%0d data=%h expected none",
                 cyc, rf_rd, rf_wdata);
      end
    end else if (wq.size() > 0 && wq[0].cyc == cyc) begin
      w = wq.pop_front();
      checks++;
      $display("FAIL missing_write cyc=%0d actual rf_wen=%b expected rd=%0d data=%h",
               cyc, rf_wen, w.rd, w.data);
    end
  end

  initial begin
    stim_t t;
    do_reset();

    // fpu result alone: written next cycle with its flags
    t = '0; t.fd = 1; t.frd = 5'd3; t.fdat = 32'h3F80_0000; t.ffl = 5'h01; step(t);
    t = '0; step(t);

    // load and fpu result collide: load first, fpu result one cycle later
    t = '0; t.lv = 1; t.lrd = 5'd5; t.ld = 32'hAAAA_5555;
    t.fd = 1; t.frd = 5'd7; t.fdat = 32'h1234_5678; t.ffl = 5'h02; step(t);
    t = '0; step(t);
    t = '0; step(t);

    // held across three back-to-back loads, including a load to register 0
    t = '0; t.lv = 1; t.lrd = 5'd1; t.ld = 32'h0000_0011;
    t.fd = 1; t.frd = 5'd2; t.fdat = 32'hCAFE_F00D; t.ffl = 5'h08; step(t);
    for (int i = 0; i < 3; i++) begin
      t = '0; t.lv = 1; t.lrd = 5'(i); t.ld = 32'hD000_0000 + 32'(i); step(t);
    end
    t = '0; step(t);

    // WAW block on register 9 until its FPU write lands
    t = '0; t.iv = 1; t.ird = 5'd9; t.r1 = 5'd9; step(t);
    for (int i = 0; i < 3; i++) begin
      t = '0; t.iv = 1; t.ird = 5'd9; t.r1 = 5'd9; t.r2 = 5'd4; step(t);
    end
    t = '0; t.iv = 1; t.ird = 5'd9; t.r1 = 5'd9;
    t.fd = 1; t.frd = 5'd9; t.fdat = 32'h4000_0000; step(t);
    t = '0; t.iv = 1; t.ird = 5'd9; t.r1 = 5'd9; step(t);
    t = '0; t.iv = 1; t.ird = 5'd9; t.r1 = 5'd9; step(t);
    t = '0; t.r1 = 5'd9; step(t);

    // clear coinciding with a flag update keeps the new flags
    t = '0; t.fd = 1; t.frd = 5'd10; t.fdat = 32'h1; t.ffl = 5'h04; t.clr = 1; step(t);
    t = '0; step(t);

    // reset while a result is held: it must never reach the port
    t = '0; t.lv = 1; t.lrd = 5'd12; t.ld = 32'h0BAD_0BAD;
    t.fd = 1; t.frd = 5'd13; t.fdat = 32'hDEAD_BEEF; t.ffl = 5'h10; t.iv = 1; t.ird = 5'd14;
    step(t);
    do_reset();
    t = '0; step(t);
    t = '0; step(t);

    for (int i = 0; i < 800; i++) begin
      int k;
      if (i == 400) do_reset();
      t = '0;
      t.lv  = ($urandom_range(0, 2) == 0);
      t.lrd = 5'($urandom_range(0, 31));
      t.ld  = $urandom;
      if (pend.size() == 0 && inflight.size() > 0 && $urandom_range(0, 1) == 1) begin
        k = $urandom_range(0, inflight.size() - 1);
        t.fd = 1; t.frd = inflight[k]; inflight.delete(k);
        t.fdat = $urandom; t.ffl = 5'($urandom_range(0, 31));
      end
      t.iv  = $urandom_range(0, 1);
      t.ird = 5'($urandom_range(0, 7));
      t.clr = ($urandom_range(0, 15) == 0);
      t.r1  = 5'($urandom_range(0, 7));
      t.r2  = 5'($urandom_range(0, 7));
      step(t);
    end

    for (int i = 0; i < 4; i++) begin
      t = '0; step(t);
    end
    @(posedge clk); #1;
    chk("drain_writes", wq.size(), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
